// File: rtl/instr_prefetch_buffer_if.sv
// ============================================================================
//  Module  : instr_prefetch_buffer_if
//  Brief   : Memory fetch, decode delivery and redirect signals of the prefetch buffer
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_prefetch_buffer_if #(
   parameter int DEPTH = 4
);
   logic                     redirect_valid;
   logic [31:0]              redirect_pc;
   logic                     imem_req;
   logic [31:0]              imem_addr;
   logic                     imem_gnt;
   logic                     imem_rvalid;
   logic [31:0]              imem_rdata;
   logic                     inst_valid;
   logic [31:0]              inst_data;
   logic [31:0]              inst_pc;
   logic                     inst_ready;
   logic [$clog2(DEPTH):0]   occupancy;

   modport master (
      input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
      output imem_req, imem_addr, inst_valid, inst_data, inst_pc, occupancy
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
      input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, occupancy
   );
endinterface

`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
// ============================================================================
//  Module  : instr_prefetch_buffer
//  Brief   : Sequential instruction prefetcher with a DEPTH-entry {pc,word} FIFO
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module instr_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                    clock,
   input  logic                    reset,
   instr_prefetch_buffer_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW:0] c_depth = (CW+1)'(DEPTH);

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_drop;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [63:0]   r_mem [DEPTH];

   logic [CW:0]   w_credit_used;
   logic          w_req;
   logic          w_grant;
   logic          w_rvalid;
   logic          w_push;
   logic          w_valid;
   logic          w_pop;

   // Words still in flight hold a slot, including the ones destined to be dropped.
   assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
   assign w_req    = !reset && !bus.redirect_valid && (w_credit_used < c_depth);
   assign w_grant  = w_req && bus.imem_gnt;
   assign w_rvalid = bus.imem_rvalid && (r_outstanding != '0);
   assign w_push   = w_rvalid && (r_drop == '0) && !bus.redirect_valid;
   assign w_valid  = (r_count != '0);
   assign w_pop    = w_valid && bus.inst_ready;

   assign bus.imem_req   = w_req;
   assign bus.imem_addr  = r_fetch_pc;
   assign bus.inst_valid = !reset && w_valid;
   assign bus.inst_pc    = reset ? 32'h0 : r_mem[r_rd_ptr][63:32];
   assign bus.inst_data  = reset ? 32'h0 : r_mem[r_rd_ptr][31:0];
   assign bus.occupancy  = reset ? '0 : r_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop        <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
      end else if (bus.redirect_valid) begin
         // Everything still owed by memory after this cycle becomes drop debt.
         r_fetch_pc    <= bus.redirect_pc;
         r_resp_pc     <= bus.redirect_pc;
         r_count       <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_outstanding <= r_outstanding - CW'(w_rvalid);
         r_drop        <= r_outstanding - CW'(w_rvalid);
      end else begin
         if (w_grant)
            r_fetch_pc <= r_fetch_pc + 32'd4;
         if (w_grant && !w_rvalid)
            r_outstanding <= r_outstanding + CW'(1);
         else if (!w_grant && w_rvalid)
            r_outstanding <= r_outstanding - CW'(1);
         if (w_rvalid && (r_drop != '0))
            r_drop <= r_drop - CW'(1);
         if (w_push) begin
            r_wr_ptr  <= r_wr_ptr + AW'(1);
            r_resp_pc <= r_resp_pc + 32'd4;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)
            r_count <= r_count + CW'(1);
         else if (!w_push && w_pop)
            r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= {r_resp_pc, bus.imem_rdata};
      end
   end
endmodule

`default_nettype wire
